// File: rtl/div_seq_pkg.sv
// Shared constants for the sequential divider: opcode encodings, FSM state codes and
// the counter-width helper.
package div_seq_pkg;

   localparam logic [4:0] ALU_DIV  = 5'h10;
   localparam logic [4:0] ALU_DIVU = 5'h11;
   localparam logic [4:0] ALU_REM  = 5'h12;
   localparam logic [4:0] ALU_REMU = 5'h13;

   localparam logic [1:0] DIV_ST_IDLE = 2'd0;
   localparam logic [1:0] DIV_ST_CALC = 2'd1;
   localparam logic [1:0] DIV_ST_DONE = 2'd2;

   // Counter must hold XLEN itself, hence one bit more than $clog2.
   function automatic int unsigned div_cnt_w(input int unsigned xlen);
      return $clog2(xlen) + 1;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder and
// subtract the divisor when it fits.
module div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] part_rem,
   input  logic            dvd_bit,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] next_rem,
   output logic            q_bit
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   // The remainder is always below the divisor, so after subtraction it fits in XLEN bits.
   always_comb begin
      shifted  = {part_rem, dvd_bit};
      diff     = shifted - {1'b0, divisor};
      q_bit    = (shifted >= {1'b0, divisor});
      next_rem = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
   end

endmodule

// File: rtl/div_seq.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU and their word forms, with a valid/ready
// handshake, single-cycle early-out for special cases and synchronous flush.
module div_seq
   import div_seq_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            s_32,
   input  logic [4:0]      opcode,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] rd
);

   localparam int unsigned DIV_CNT_W = div_cnt_w(XLEN);

   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r       = '0;
      r[31:0] = v;
      for (int i = 32; i < XLEN; i++) r[i] = sgn & v[31];
      return r;
   endfunction

   logic [1:0]           state_q;
   logic [DIV_CNT_W-1:0] count_q;
   logic [XLEN-1:0]      dvd_q;
   logic [XLEN-1:0]      rem_q;
   logic [XLEN-1:0]      dsr_q;
   logic                 neg_q;
   logic                 rsel_q;
   logic                 word_q;
   logic [XLEN-1:0]      rd_q;

   logic                 is_signed;
   logic                 is_rem;
   logic                 op_known;
   logic                 special;
   logic                 neg_init;
   logic [XLEN-1:0]      opa;
   logic [XLEN-1:0]      opb;
   logic [XLEN-1:0]      abs_a;
   logic [XLEN-1:0]      abs_b;
   logic [XLEN-1:0]      min_neg;
   logic [XLEN-1:0]      spec_res;
   logic [XLEN-1:0]      spec_fin;
   logic [XLEN-1:0]      dvd_init;
   logic [DIV_CNT_W-1:0] cnt_init;

   logic [XLEN-1:0]      next_rem;
   logic                 q_bit;
   logic [XLEN-1:0]      q_fin;
   logic [XLEN-1:0]      res_mag;
   logic [XLEN-1:0]      res_fix;
   logic [XLEN-1:0]      done_res;

   // Operand preparation and special-case detection for the request at the input.
   always_comb begin
      op_known  = 1'b1;
      is_signed = 1'b0;
      is_rem    = 1'b0;
      case (opcode)
         ALU_DIV:  is_signed = 1'b1;
         ALU_DIVU: op_known  = 1'b1;
         ALU_REM: begin
            is_signed = 1'b1;
            is_rem    = 1'b1;
         end
         ALU_REMU: is_rem    = 1'b1;
         default:  op_known  = 1'b0;
      endcase

      opa     = s_32 ? ext32(rs1[31:0], is_signed) : rs1;
      opb     = s_32 ? ext32(rs2[31:0], is_signed) : rs2;
      min_neg = s_32 ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
      abs_a   = (is_signed && opa[XLEN-1]) ? -opa : opa;
      abs_b   = (is_signed && opb[XLEN-1]) ? -opb : opb;

      // Word operands sit in the top half so that 32 shifts leave the quotient in [31:0].
      dvd_init = s_32 ? (abs_a << (XLEN - 32)) : abs_a;
      cnt_init = s_32 ? DIV_CNT_W'(32) : DIV_CNT_W'(XLEN);
      neg_init = is_signed & (is_rem ? opa[XLEN-1] : (opa[XLEN-1] ^ opb[XLEN-1]));

      special  = 1'b1;
      spec_res = '0;
      if (!op_known) begin
         spec_res = '0;
      end else if (opb == '0) begin
         spec_res = is_rem ? opa : '1;
      end else if (is_signed && (opa == min_neg) && (opb == '1)) begin
         spec_res = is_rem ? '0 : opa;
      end else begin
         special = 1'b0;
      end
      spec_fin = s_32 ? ext32(spec_res[31:0], 1'b1) : spec_res;
   end

   div_step #(
      .XLEN(XLEN)
   ) u_step (
      .part_rem(rem_q),
      .dvd_bit (dvd_q[XLEN-1]),
      .divisor (dsr_q),
      .next_rem(next_rem),
      .q_bit   (q_bit)
   );

   // Sign fix-up applied to the final step's outputs on the way into DONE.
   always_comb begin
      q_fin    = {dvd_q[XLEN-2:0], q_bit};
      res_mag  = rsel_q ? next_rem : q_fin;
      res_fix  = neg_q ? -res_mag : res_mag;
      done_res = word_q ? ext32(res_fix[31:0], 1'b1) : res_fix;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= DIV_ST_IDLE;
         count_q <= '0;
         dvd_q   <= '0;
         rem_q   <= '0;
         dsr_q   <= '0;
         neg_q   <= 1'b0;
         rsel_q  <= 1'b0;
         word_q  <= 1'b0;
         rd_q    <= '0;
      end else if (flush) begin
         state_q <= DIV_ST_IDLE;
      end else begin
         case (state_q)
            DIV_ST_IDLE: begin
               if (in_valid) begin
                  if (special) begin
                     rd_q    <= spec_fin;
                     state_q <= DIV_ST_DONE;
                  end else begin
                     dvd_q   <= dvd_init;
                     rem_q   <= '0;
                     dsr_q   <= abs_b;
                     count_q <= cnt_init;
                     neg_q   <= neg_init;
                     rsel_q  <= is_rem;
                     word_q  <= s_32;
                     state_q <= DIV_ST_CALC;
                  end
               end
            end
            DIV_ST_CALC: begin
               dvd_q   <= q_fin;
               rem_q   <= next_rem;
               count_q <= count_q - DIV_CNT_W'(1);
               if (count_q == DIV_CNT_W'(1)) begin
                  rd_q    <= done_res;
                  state_q <= DIV_ST_DONE;
               end
            end
            DIV_ST_DONE: begin
               if (out_ready) state_q <= DIV_ST_IDLE;
            end
            default: state_q <= DIV_ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == DIV_ST_IDLE);
   assign out_valid = (state_q == DIV_ST_DONE);
   assign rd        = rd_q;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: XLEN=32 and XLEN=64 instances checked every cycle against an
// arithmetic reference model, plus directed and randomized traffic.
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        out_ready;
   logic        s_32;
   logic [4:0]  opcode;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        iv[2];
   logic        ir[2];
   logic        ov[2];
   logic [31:0] rd32;
   logic [63:0] rd64;
   logic [63:0] rdv[2];

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   // Reference-model state per instance: request in flight, its result and timing.
   bit          pend[2];
   int          age[2];
   int          lat_m[2];
   logic [63:0] exp_r[2];
   logic [63:0] mrd[2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign rdv[0] = {32'b0, rd32};
   assign rdv[1] = rd64;

   div_seq #(.XLEN(32)) u_div32 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (iv[0]),
      .in_ready (ir[0]),
      .s_32     (1'b0),
      .opcode   (opcode),
      .rs1      (rs1[31:0]),
      .rs2      (rs2[31:0]),
      .out_valid(ov[0]),
      .out_ready(out_ready),
      .rd       (rd32)
   );

   div_seq #(.XLEN(64)) u_div64 (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (iv[1]),
      .in_ready (ir[1]),
      .s_32     (s_32),
      .opcode   (opcode),
      .rs1      (rs1),
      .rs2      (rs2),
      .out_valid(ov[1]),
      .out_ready(out_ready),
      .rd       (rd64)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Result and latency (cycles from accept to first out_valid, counting the accept cycle).
   task automatic model(input int xl, input bit s32, input logic [4:0] op,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat);
      bit          w;
      bit          sgn;
      bit          isrem;
      bit          known;
      longint      sa;
      longint      sb;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] r;
      longint      mn;
      w     = (xl == 32) || s32;
      known = (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
      sgn   = (op == ALU_DIV) || (op == ALU_REM);
      isrem = (op == ALU_REM) || (op == ALU_REMU);
      if (w) begin
         sa = longint'($signed(a[31:0]));
         sb = longint'($signed(b[31:0]));
         ua = {32'b0, a[31:0]};
         ub = {32'b0, b[31:0]};
         mn = longint'($signed(32'h8000_0000));
      end else begin
         sa = $signed(a);
         sb = $signed(b);
         ua = a;
         ub = b;
         mn = longint'(64'h8000_0000_0000_0000);
      end
      lat = w ? 33 : 65;
      if (!known) begin
         r   = '0;
         lat = 1;
      end else if (ub == 0) begin
         r   = isrem ? (sgn ? sa : ua) : '1;
         lat = 1;
      end else if (sgn && sb == -1 && sa == mn) begin
         r   = isrem ? 64'd0 : sa;
         lat = 1;
      end else if (sgn) begin
         r = isrem ? (sa % sb) : (sa / sb);
      end else begin
         r = isrem ? (ua % ub) : (ua / ub);
      end
      if (w) r = (xl == 64) ? {{32{r[31]}}, r[31:0]} : {32'b0, r[31:0]};
      res = r;
   endtask

   // Compare process: outputs of both instances against the model on every cycle.
   initial begin
      logic [63:0] er;
      int          el;
      bit          exp_ov;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
               exp_ov = pend[d] && (age[d] >= lat_m[d]);
               chk($sformatf("in_ready[%0d]", d), 64'(ir[d]), 64'(!pend[d]));
               chk($sformatf("out_valid[%0d]", d), 64'(ov[d]), 64'(exp_ov));
               chk($sformatf("rd[%0d]", d), rdv[d], mrd[d]);
               if (!rst_n) begin
                  pend[d] = 1'b0;
                  mrd[d]  = '0;
               end else if (flush) begin
                  pend[d] = 1'b0;
               end else if (pend[d]) begin
                  if (exp_ov) begin
                     if (out_ready) pend[d] = 1'b0;
                  end else begin
                     age[d]++;
                     if (age[d] == lat_m[d]) mrd[d] = exp_r[d];
                  end
               end else if (iv[d]) begin
                  model((d == 0) ? 32 : 64, (d == 0) ? 1'b0 : s_32, opcode, rs1, rs2, er, el);
                  exp_r[d] = er;
                  lat_m[d] = el;
                  pend[d]  = 1'b1;
                  age[d]   = 1;
                  if (el == 1) mrd[d] = er;
               end
            end
         end
      end
   end

   task automatic send(input int d, input bit s32, input logic [4:0] op,
                       input logic [63:0] a, input logic [63:0] b, output int t_acc);
      int n;
      opcode = op;
      rs1    = a;
      rs2    = b;
      s_32   = s32;
      iv[d]  = 1'b1;
      n      = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ir[d] && n < 300);
      if (n >= 300) chk("send_timeout", 64'(ir[d]), 64'd1);
      @(posedge clk);
      #1;
      iv[d] = 1'b0;
      t_acc = cyc;
   endtask

   task automatic collect(input int d, input bit bp, output int lat, output logic [63:0] r);
      lat = 1;
      while (!ov[d] && lat < 300) begin
         if (bp) out_ready = ($urandom_range(0, 1) != 0);
         @(posedge clk);
         #1;
         lat++;
      end
      if (lat >= 300) chk("collect_timeout", 64'(ov[d]), 64'd1);
      r = rdv[d];
   endtask

   task automatic drain(input bit bp);
      bit taken;
      int n;
      n = 0;
      do begin
         out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
         taken     = out_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!taken && n < 50);
      out_ready = 1'b1;
   endtask

   task automatic directed(input string nm, input int d, input bit s32, input logic [4:0] op,
                           input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] lit, input int lit_lat);
      int          t;
      int          lat;
      logic [63:0] r;
      send(d, s32, op, a, b, t);
      collect(d, 1'b0, lat, r);
      chk({nm, "_rd"}, r, lit);
      chk({nm, "_lat"}, 64'(lat), 64'(lit_lat));
      drain(1'b0);
   endtask

   initial begin
      int          t;
      int          t_rel;
      int          lat;
      int          el;
      int          d;
      bit          s32;
      bit          seen;
      logic [4:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] r;
      logic [63:0] er;
      logic [4:0]  ops[5];

      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      s_32      = 1'b0;
      opcode    = '0;
      rs1       = '0;
      rs2       = '0;
      iv[0]     = 1'b0;
      iv[1]     = 1'b0;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0;
         mrd[i]  = '0;
         age[i]  = 0;
         lat_m[i] = 0;
      end

      @(posedge clk);
      #1;
      mon_en = 1'b1;
      chk("reset_in_ready", 64'(ir[0]), 64'd1);
      chk("reset_out_valid", 64'(ov[1]), 64'd0);
      chk("reset_rd", rd64, 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Pin the reference model on hand-worked cases.
      model(32, 1'b0, ALU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, er, el);
      chk("model_div", er, 64'h0000_0000_FFFF_FFFD);
      chk("model_div_lat", 64'(el), 64'd33);
      model(64, 1'b1, ALU_DIVU, 64'h0000_0000_8000_0000, 64'd1, er, el);
      chk("model_divuw", er, 64'hFFFF_FFFF_8000_0000);
      model(64, 1'b0, ALU_REM, 64'h8000_0000_0000_0000, '1, er, el);
      chk("model_rem_ovf", er, 64'd0);
      chk("model_rem_ovf_lat", 64'(el), 64'd1);

      directed("div_m7_2", 0, 1'b0, ALU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'h0000_0000_FFFF_FFFD, 33);
      directed("rem_m7_2", 0, 1'b0, ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'h0000_0000_FFFF_FFFF, 33);
      directed("divu_by0", 0, 1'b0, ALU_DIVU, 64'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFF, 1);
      directed("remu_by0", 0, 1'b0, ALU_REMU, 64'd5, 64'd0, 64'd5, 1);
      directed("div_ovf", 0, 1'b0, ALU_DIV, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 1);
      directed("rem_ovf", 0, 1'b0, ALU_REM, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0, 1);
      directed("divuw", 1, 1'b1, ALU_DIVU, 64'h0000_0000_8000_0000, 64'd1,
               64'hFFFF_FFFF_8000_0000, 33);
      directed("div64", 1, 1'b0, ALU_DIV, 64'd100, 64'd7, 64'd14, 65);
      directed("remw_neg", 1, 1'b1, ALU_REM, 64'h0000_0000_FFFF_FFF9, 64'd2, '1, 33);
      directed("bad_op", 1, 1'b0, 5'h1F, 64'd9, 64'd3, 64'd0, 1);

      // Backpressure, then a back-to-back request offered in the DONE cycle.
      out_ready = 1'b0;
      send(0, 1'b0, ALU_DIVU, 64'd100, 64'd7, t);
      collect(0, 1'b0, lat, r);
      chk("bp_rd_first", r, 64'd14);
      repeat (5) begin
         @(posedge clk);
         #1;
         chk("bp_rd_hold", rdv[0], 64'd14);
         chk("bp_in_ready", 64'(ir[0]), 64'd0);
      end
      t_rel     = cyc;
      out_ready = 1'b1;
      send(0, 1'b0, ALU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, t);
      chk("b2b_accept_cycle", 64'(t), 64'(t_rel + 2));
      collect(0, 1'b0, lat, r);
      chk("b2b_rd", r, 64'h0000_0000_FFFF_FFFF);
      drain(1'b0);

      // Flush ten cycles into a CALC with a competing request in the same cycle.
      send(0, 1'b0, ALU_DIVU, 64'd1000, 64'd3, t);
      repeat (9) @(posedge clk);
      #1;
      flush  = 1'b1;
      iv[0]  = 1'b1;
      opcode = ALU_DIVU;
      rs1    = 64'd0;
      rs2    = 64'd0;
      @(posedge clk);
      #1;
      flush = 1'b0;
      iv[0] = 1'b0;
      chk("flush_in_ready", 64'(ir[0]), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= ov[0];
      end
      chk("flush_no_valid", 64'(seen), 64'd0);
      chk("flush_rd_kept", rdv[0], 64'h0000_0000_FFFF_FFFF);

      // Reset in the middle of a 64-bit CALC.
      send(1, 1'b0, ALU_DIV, 64'd100, 64'd7, t);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mid_out_valid", 64'(ov[1]), 64'd0);
      chk("rst_mid_in_ready", 64'(ir[1]), 64'd1);
      chk("rst_mid_rd", rd64, 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic with random output backpressure.
      ops[0] = ALU_DIV;
      ops[1] = ALU_DIVU;
      ops[2] = ALU_REM;
      ops[3] = ALU_REMU;
      ops[4] = 5'h07;
      for (int i = 0; i < 80; i++) begin
         d   = $urandom_range(0, 1);
         s32 = (d == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         op  = ($urandom_range(0, 15) == 0) ? ops[4] : ops[$urandom_range(0, 3)];
         a   = {$urandom, $urandom};
         b   = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0: b = '0;
            1: begin
               a = (d == 0 || s32) ? 64'h0000_0000_8000_0000 : 64'h8000_0000_0000_0000;
               b = '1;
            end
            2: begin
               a = 64'($urandom_range(0, 1000));
               b = 64'($urandom_range(1, 20));
            end
            3: b = {{48{b[15]}}, b[15:0]};
            default: ;
         endcase
         send(d, s32, op, a, b, t);
         collect(d, 1'b1, lat, r);
         model((d == 0) ? 32 : 64, s32, op, a, b, er, el);
         chk("rand_rd", r, er);
         chk("rand_lat", 64'(lat), 64'(el));
         drain(1'b1);
      end

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Iterative radix-2 integer divider for the RV M-extension: DIV, DIVU, REM, REMU, plus the W variants (s_32).
- Successor to the single-cycle combinational divider. Adds a valid/ready handshake, a multi-cycle datapath with one quotient bit per cycle, a 1-cycle early-out for special cases, and pipeline flush.
- Sits in the execute stage beside the ALU and multiplier. Issue stalls while in_ready is low.

Parameters:
- XLEN, 32, operand/result width; legal values 32 or 64.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  abort any in-flight or pending operation
- in_valid  in  1  request valid
- in_ready  out  1  divider can accept a request
- s_32  in  1  word op (XLEN=64 only): operate on [31:0], sign-extend the result; tie 0 when XLEN=32
- opcode  in  5  ALU_DIV / ALU_DIVU / ALU_REM / ALU_REMU (shared defines)
- rs1  in  XLEN  dividend
- rs2  in  XLEN  divisor
- out_valid  out  1  rd is valid
- out_ready  in  1  consumer takes the result
- rd  out  XLEN  result; held stable while out_valid && !out_ready

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, in_ready=1, out_valid=0, rd=0, all internal registers 0.
  - Reset mid-operation discards the operation.
- States:
  - IDLE: in_ready=1. On in_valid && !flush, latch opcode, s_32 and operands.
    - Special case → DONE.
    - Otherwise → CALC with count=N, where N=32 if s_32 else XLEN.
  - CALC: one restoring step per cycle on |dividend| and |divisor| (signed ops) or the raw values (unsigned ops). count decrements each cycle; when count reaches 1, go to DONE next edge.
  - DONE: out_valid=1. On out_ready → IDLE. No new request is accepted in DONE, even when out_ready=1.
- Latency: request accepted at edge T.
  - Normal: out_valid first high in cycle T+N+1 (33 cycles for a 32-bit op).
  - Special case: out_valid high in cycle T+1.
- Operand preparation, word mode:
  - Signed ops use sign-extended rs[31:0].
  - Unsigned ops use zero-extended rs[31:0].
  - Every word-mode result, including DIVUW/REMUW, is sign-extended from bit 31.
- Special cases, checked at accept on the prepared operands:
  - Divisor 0: DIV/DIVU → all ones (-1); REM/REMU → dividend (word mode: sign-extended [31:0]).
  - Signed overflow (dividend = most negative of the op width, divisor = -1): DIV → dividend; REM → 0.
  - Unknown opcode: rd=0 via the early-out path.
- Sign fix-up on the DONE transition:
  - Quotient is negated when the operand signs differ (signed DIV only).
  - Remainder takes the sign of the dividend (signed REM only).
  - Result is truncated to the op width, then extended.
- flush: synchronous, priority over everything except reset.
  - Next state IDLE, out_valid=0, the result is dropped.
  - A request presented in the same cycle as flush is not accepted.
- in_ready is purely state-based (state==IDLE) and has no combinational path from in_valid.
- rd changes only on entry to DONE.

Decomposition:
- Opcode macros stay in the shared defines header (ALU_DIV..ALU_REMU).
- New shared constants:
  - DIV_ST_IDLE / DIV_ST_CALC / DIV_ST_DONE (2-bit state encoding)
  - DIV_CNT_W = $clog2(XLEN)+1
- Sub-module div_step (combinational): inputs partial remainder, shifted dividend bit and divisor; outputs next remainder and quotient bit. Instantiated once in div_seq.

Test Plan:
- XLEN=32, DIV rs1=-7, rs2=2 → rd=0xFFFFFFFD (-3) at cycle T+33; REM same operands → 0xFFFFFFFF (-1).
- DIVU rs1=0xFFFFFFFF, rs2=0 → rd=0xFFFFFFFF at T+1; REMU rs1=5, rs2=0 → rd=5 at T+1.
- DIV rs1=0x80000000, rs2=-1 → rd=0x80000000 at T+1; REM same → 0.
- XLEN=64, s_32=1, DIVU rs1=0x0000_0000_8000_0000, rs2=1 → rd=0xFFFF_FFFF_8000_0000 at T+33; s_32=0, DIV 100/7 → 14 at T+65.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → rd stable, in_ready=0 throughout; out_ready=1 → IDLE next cycle, and a back-to-back request is accepted that cycle.
- flush at T+10 of a CALC, with in_valid=1 in the same cycle → out_valid never asserts, in_ready=1 at T+11, the flushed-cycle request is not accepted; rst_n=0 mid-CALC → outputs at reset values next cycle.
